// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide, byte-addressed data memory.
// Word-aligns accesses, extends sub-word loads and merges sub-word stores by read-modify-write.
//
// state   | meaning
// IDLE    | ready for a request; accept on req_valid_i
// RD      | memory read of the aligned word (loads and sub-word stores)
// WR      | memory write of the merged or full store word
// RESP    | one-cycle response pulse, then back to IDLE
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        write_q;
  logic        err_q;

  logic        accept;
  logic [31:0] req_aligned;
  logic [32:0] req_last_byte;
  logic        req_out_of_range;
  logic        req_misaligned;
  logic        req_err;
  logic [31:0] aligned_q;
  logic [31:0] store_word;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign accept = (state_q == ST_IDLE) && req_valid_i;

  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign req_aligned      = {req_addr_i[31:2], 2'b00};
  assign req_last_byte    = {1'b0, req_aligned} + 33'd3;
  assign req_out_of_range = (req_last_byte >= 33'(MEM_BYTES));
  assign req_misaligned   = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                            ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
  assign req_err          = (req_size_i == SZ_ILL) || req_misaligned || req_out_of_range;

  assign aligned_q = {addr_q[31:2], 2'b00};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        size_q     <= req_size_i;
        unsigned_q <= req_unsigned_i;
        write_q    <= req_write_i;
        err_q      <= req_err;
      end
      if (state_q == ST_RD) begin
        word_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = ST_RESP;
          end else if (req_write_i && (req_size_i == SZ_WORD)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sub-word stores overwrite only their lanes of the word captured in RD
  always_comb begin
    store_word = word_q;
    case (size_q)
      SZ_BYTE: store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  always_comb begin
    load_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
    load_half = word_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_word = unsigned_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
      SZ_HALF: load_word = unsigned_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_word = word_q;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    mem_addr_o   = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_wdata_o  = '0;
    case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_RD: begin
        mem_read_o = 1'b1;
        mem_addr_o = aligned_q;
      end
      ST_WR: begin
        mem_write_o = 1'b1;
        mem_addr_o  = aligned_q;
        mem_wdata_o = store_word;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        if (!write_q && !err_q) begin
          resp_rdata_o = load_word;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator for the word-wide, byte-addressed data memory.
- Takes load/store requests from the MEM stage and runs the memory handshake on the pipeline's behalf.
- Word-aligns every memory access and extracts plus sign/zero-extends byte and halfword load data.
- Performs read-modify-write for byte and halfword stores, and rejects misaligned or out-of-range accesses without touching memory.

Parameters:
MEM_BYTES, 32, size of the attached data memory in bytes; any access whose aligned word address + 3 >= MEM_BYTES is out of range.

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_i  input  1  asynchronous active-low reset
req_valid_i  input  1  request present
req_ready_o  output  1  unit can accept a request (IDLE only)
req_write_i  input  1  1 = store, 0 = load
req_size_i  input  2  0 byte, 1 halfword, 2 word, 3 illegal (treated as error)
req_unsigned_i  input  1  zero-extend load (lbu/lhu); ignored for word and for stores
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-justified
resp_valid_o  output  1  one-cycle response pulse
resp_rdata_o  output  32  extended load data; 0 for stores and errors
resp_err_o  output  1  misaligned/out-of-range/illegal size; valid with resp_valid_o
mem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
mem_read_o  output  1  memory read enable
mem_write_o  output  1  memory write enable; memory commits on posedge
mem_wdata_o  output  32  word to write
mem_rdata_i  input  32  combinational read data; valid in the same cycle mem_read_o=1

Behaviour:
- Reset (async, rst_i=0):
  - State goes to IDLE immediately.
  - All outputs go to 0 except req_ready_o=1.
  - All internal registers clear.
  - A reset asserted mid-operation kills the request: mem_write_o drops at once and no partial write occurs.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready_o=1; a request is accepted on a posedge with req_valid_i=1.
  - Accept registers addr, size, unsigned, write, wdata.
  - Accept computes err = (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (aligned+3 >= MEM_BYTES).
  - err -> RESP. Load -> RD. Word store -> WR. Byte/half store -> RD.
- RD:
  - mem_read_o=1, mem_addr_o=aligned address.
  - mem_rdata_i is captured into a word register at the posedge.
  - Load -> RESP. Sub-word store -> WR.
- WR:
  - mem_write_o=1, mem_addr_o=aligned address.
  - Word store: mem_wdata_o = wdata.
  - Byte store: the captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - Half store: the captured word with lanes {addr[1],1'b0} and {addr[1],1'b1} replaced by wdata[15:0].
  - Next state -> RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle.
  - resp_err_o is set from err.
  - resp_rdata_o for a load: the selected byte or half, sign-extended unless unsigned; full word for size 2.
  - resp_rdata_o is 0 for stores and errors.
  - Next state -> IDLE.
- Response has no backpressure.
- mem_read_o and mem_write_o are never both 1. Neither is asserted in IDLE, RESP, or on an error path.
- Latency, counted from the accept edge T to the cycle resp_valid_o=1:
  - Error: T+1.
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
- req_ready_o=0 from the cycle after accept until IDLE re-entry. The minimum request spacing is therefore latency+1 cycles.
- req_* inputs are ignored outside IDLE.
- Outputs:
  - mem_addr_o and mem_wdata_o are 0 when no memory access is active.
  - resp_rdata_o and resp_err_o are 0 when resp_valid_o=0.

Test Plan:
- Memory bytes 0x8..0xB = BB,AA,99,88; lb addr 0x9, signed -> RD at T+1 with mem_addr_o=0x8; resp_valid at T+2 with rdata 0xFFFFFFAA, err 0.
- lhu addr 0xA -> resp_valid at T+2 with rdata 0x00008899; lw addr 0x8 -> rdata 0x8899AABB.
- sb wdata 0x12345611 addr 0x9 -> RD at T+1, WR at T+2 with mem_wdata_o 0x889911BB; resp_valid at T+3, rdata 0. A following lw 0x8 returns 0x889911BB.
- Misaligned and out-of-range accesses:
  - sw addr 0x6 -> resp_valid at T+1 with err 1; mem_read_o and mem_write_o stay 0 throughout.
  - lw addr 0x1C (MEM_BYTES=32) is accepted (0x1C+3 = 31).
  - lw addr 0x20 -> err 1.
- Reset during a sub-word store:
  - Sequence: sh 0xBEEF at addr 0xA with rst_i=0 pulsed during RD.
  - Required: state IDLE immediately, no WR cycle, memory unchanged (lw 0x8 -> 0x8899AABB), req_ready_o=1 while in reset.
- Back-to-back requests with req_valid_i held high:
  - Sequence: lw 0x0 then lw 0x4.
  - Required: second accept one cycle after the first resp_valid_o; req_* changes while req_ready_o=0 have no effect.
